// File: rtl/alu_arbiter_pkg.sv
// Shared opcode constants, FSM state encoding and default widths for the
// two-requester ALU arbiter.
package alu_arbiter_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int CODE_W_DEF = 4;

  localparam int OP_ADD = 1;
  localparam int OP_SUB = 2;
  localparam int OP_SHL = 3;
  localparam int OP_SHR = 4;
  localparam int OP_AND = 5;
  localparam int OP_OR  = 6;
  localparam int OP_NOT = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_core.sv
// Combinational ALU: (a, b, code) -> (ans, err). Unknown opcodes give ans=0
// with err set.
module alu_core
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [CODE_W-1:0] code,
  output logic [WIDTH-1:0]  ans,
  output logic              err
);

  logic a_nz;
  logic b_nz;

  assign a_nz = |a;
  assign b_nz = |b;

  always_comb begin
    ans = '0;
    err = 1'b0;
    case (code)
      CODE_W'(OP_ADD): ans = a + b;
      CODE_W'(OP_SUB): ans = a - b;
      // Shift amounts of WIDTH or more flush every bit out.
      CODE_W'(OP_SHL): ans = (int'(b) >= WIDTH) ? '0 : (a << b);
      CODE_W'(OP_SHR): ans = (int'(b) >= WIDTH) ? '0 : (a >> b);
      CODE_W'(OP_AND): ans = {{(WIDTH-1){1'b0}}, a_nz & b_nz};
      CODE_W'(OP_OR):  ans = {{(WIDTH-1){1'b0}}, a_nz | b_nz};
      CODE_W'(OP_NOT): ans = ~a;
      default:         err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that serialises two requesters onto one ALU, one
// operation in flight: IDLE (grant) -> EXEC (compute) -> RESP (hold result).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*WIDTH-1:0]    req_a,
  input  logic [2*WIDTH-1:0]    req_b,
  input  logic [2*CODE_W-1:0]   req_code,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [WIDTH-1:0]      rsp_ans,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready of
  // the same bit are both 1. A requester holds valid and its payload stable
  // until accepted; rsp_valid holds with a stable payload until rsp_ready.

  state_t             state;
  logic               ptr;
  logic               gnt_idx;
  logic               gnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CODE_W-1:0]  code_q;
  logic [WIDTH-1:0]   ans_q;
  logic               err_q;
  logic [WIDTH-1:0]   alu_ans;
  logic               alu_err;
  logic               accept;

  // ptr names the requester that wins a tie.
  always_comb begin
    gnt_idx   = 1'b0;
    req_ready = 2'b00;
    if (req_valid[0] && req_valid[1]) begin
      gnt_idx = ptr;
    end else begin
      gnt_idx = req_valid[1];
    end
    if ((state == ST_IDLE) && !rst && (|req_valid)) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

  alu_core #(
    .WIDTH  (WIDTH),
    .CODE_W (CODE_W)
  ) u_core (
    .a    (a_q),
    .b    (b_q),
    .code (code_q),
    .ans  (alu_ans),
    .err  (alu_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ptr    <= 1'b0;
      gnt_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      code_q <= '0;
      ans_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q    <= gnt_idx ? req_a[2*WIDTH-1:WIDTH]     : req_a[WIDTH-1:0];
            b_q    <= gnt_idx ? req_b[2*WIDTH-1:WIDTH]     : req_b[WIDTH-1:0];
            code_q <= gnt_idx ? req_code[2*CODE_W-1:CODE_W] : req_code[CODE_W-1:0];
            gnt_q  <= gnt_idx;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          ans_q <= alu_ans;
          err_q <= alu_err;
          state <= ST_RESP;
        end
        ST_RESP: begin
          // Fairness moves only once the result is taken, not at grant.
          if (rsp_ready[gnt_q]) begin
            ptr   <= ~gnt_q;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (state == ST_RESP) begin
      rsp_valid[gnt_q] = 1'b1;
    end
  end

  assign rsp_ans   = ans_q;
  assign rsp_err   = err_q;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus randomized
// traffic against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int W  = 4;
  localparam int CW = 4;
  localparam int M  = 1 << W;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*W-1:0]  req_a;
  logic [2*W-1:0]  req_b;
  logic [2*CW-1:0] req_code;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [W-1:0]    rsp_ans;
  logic            rsp_err;
  logic            busy;
  logic [1:0]      dbg_state;

  alu_arbiter #(.WIDTH(W), .CODE_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_code  (req_code),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_ans   (rsp_ans),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int last_g = -1;            // -1: nobody served since reset, requester 0 wins ties
  logic          pend_v[2];
  logic [W-1:0]  pend_a[2];
  logic [W-1:0]  pend_b[2];
  logic [CW-1:0] pend_c[2];
  logic [W:0]    exp_q[$];    // {err, ans}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model computed from the opcode rules with integer arithmetic.
  function automatic logic [W:0] ref_alu(input int a, input int b, input int c);
    int r;
    logic e;
    r = 0;
    e = 1'b0;
    case (c)
      1: r = (a + b) % M;
      2: r = (a - b + M) % M;
      3: r = (b >= W) ? 0 : (a * (1 << b)) % M;
      4: r = (b >= W) ? 0 : a / (1 << b);
      5: r = (a != 0 && b != 0) ? 1 : 0;
      6: r = (a != 0 || b != 0) ? 1 : 0;
      7: r = M - 1 - a;
      default: e = 1'b1;
    endcase
    return {e, r[W-1:0]};
  endfunction

  // driver tasks
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      req_valid[i]           = pend_v[i];
      req_a[i*W +: W]        = pend_a[i];
      req_b[i*W +: W]        = pend_b[i];
      req_code[i*CW +: CW]   = pend_c[i];
    end
  endtask

  task automatic set_req(input int i, input int a, input int b, input int c);
    pend_v[i] = 1'b1;
    pend_a[i] = W'(a);
    pend_b[i] = W'(b);
    pend_c[i] = CW'(c);
    drive();
  endtask

  task automatic randomize_req(input int i);
    set_req(i, $urandom_range(0, M-1), $urandom_range(0, M-1), $urandom_range(0, 15));
  endtask

  // Returns at a negedge where req_ready is nonzero, or flags a timeout.
  task automatic wait_ready(output bit ok);
    int waited;
    waited = 0;
    while (req_ready == 2'b00 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    ok = (req_ready != 2'b00);
    if (!ok) chk("req_ready_timeout", 0, 1);
  endtask

  // One full transaction: grant, EXEC, RESP with optional stall, handshake.
  task automatic serve_one(input int stall, input bit refill, output int g);
    bit         ok;
    logic [W:0] e;
    logic [1:0] onehot;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_rsp_valid", rsp_valid, 0);
    wait_ready(ok);
    if (!ok) begin
      g = -1;
      return;
    end
    if (pend_v[0] && pend_v[1]) g = (last_g == 0) ? 1 : 0;
    else                        g = pend_v[1] ? 1 : 0;
    onehot = 2'b00;
    onehot[g] = 1'b1;
    chk("grant", req_ready, onehot);
    exp_q.push_back(ref_alu(pend_a[g], pend_b[g], pend_c[g]));
    @(posedge clk);
    #1;
    if (refill) randomize_req(g);
    else begin
      pend_v[g] = 1'b0;
      drive();
    end
    @(negedge clk);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_busy", busy, 1);
    chk("exec_req_ready", req_ready, 0);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("rsp_valid", rsp_valid, onehot);
    chk("rsp_ans", rsp_ans, e[W-1:0]);
    chk("rsp_err", rsp_err, e[W]);
    for (int k = 0; k < stall; k++) begin
      rsp_ready = 2'b00;
      rsp_ready[1-g] = 1'b1;
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, onehot);
      chk("stall_rsp_ans", rsp_ans, e[W-1:0]);
      chk("stall_req_ready", req_ready, 0);
    end
    rsp_ready = onehot;
    if ($urandom_range(0, 1) == 1) rsp_ready[1-g] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 2'b00;
    last_g = g;
  endtask

  initial begin
    int  g;
    bit  ok;
    rst       = 1'b1;
    rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      pend_v[i] = 1'b0;
      pend_a[i] = '0;
      pend_b[i] = '0;
      pend_c[i] = '0;
    end
    set_req(0, 3, 5, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ans", rsp_ans, 0);
    chk("rst_err", rsp_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend_v[0] = 1'b0;
    drive();

    // Tie fairness straight after reset: both requesters keep valid high.
    randomize_req(0);
    randomize_req(1);
    for (int n = 0; n < 4; n++) begin
      serve_one(0, 1'b1, g);
      chk("fair_grant", g, n % 2);
    end
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    drive();

    // Single op and wrap/shift/not cases.
    set_req(0, 3, 5, 1);  serve_one(0, 1'b0, g);
    set_req(1, 2, 5, 2);  serve_one(0, 1'b0, g);
    set_req(0, 1, 4, 3);  serve_one(0, 1'b0, g);
    set_req(1, 9, 0, 7);  serve_one(0, 1'b0, g);

    // Backpressure with the other requester waiting throughout.
    set_req(0, 7, 6, 1);
    set_req(1, 12, 2, 4);
    serve_one(5, 1'b0, g);
    serve_one(5, 1'b0, g);

    // Invalid opcodes.
    set_req(0, 5, 5, 0);  serve_one(0, 1'b0, g);
    set_req(1, 5, 5, 12); serve_one(2, 1'b0, g);

    // Reset while in EXEC: no response, then requester 0 wins the next tie.
    set_req(0, 4, 4, 1);
    set_req(1, 6, 1, 2);
    @(negedge clk);
    wait_ready(ok);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstexec_req_ready", req_ready, 0);
    chk("rstexec_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_g = -1;
    chk("rstexec_busy", busy, 0);
    chk("rstexec_rsp_valid2", rsp_valid, 0);
    chk("rstexec_ans", rsp_ans, 0);
    chk("rstexec_err", rsp_err, 0);
    serve_one(0, 1'b0, g);
    chk("rstexec_grant0", g, 0);
    serve_one(0, 1'b0, g);

    // Randomized traffic.
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend_v[i] && $urandom_range(0, 1) == 1) randomize_req(i);
      end
      if (!pend_v[0] && !pend_v[1]) randomize_req($urandom_range(0, 1));
      serve_one($urandom_range(0, 3), 1'b0, g);
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 4, operand and result width in bits.
REQ-002 Parameter: CODE_W, 4, opcode width in bits.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 Port: req_valid  input  2  per-requester request strobe; bit i = requester i.
REQ-006 Port: req_ready  output  2  per-requester accept; request i is accepted in the cycle where req_valid[i] and req_ready[i] are both 1.
REQ-007 Port: req_a  input  2*WIDTH  operand a; requester i in bits [i*WIDTH +: WIDTH].
REQ-008 Port: req_b  input  2*WIDTH  operand b; same packing.
REQ-009 Port: req_code  input  2*CODE_W  opcode; requester i in bits [i*CODE_W +: CODE_W].
REQ-010 Port: rsp_valid  output  2  result valid toward requester i; one-hot or zero.
REQ-011 Port: rsp_ready  input  2  requester i accepts result.
REQ-012 Port: rsp_ans  output  WIDTH  result, shared by both requesters.
REQ-013 Port: rsp_err  output  1  opcode was invalid; qualified by rsp_valid.
REQ-014 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-015 States: IDLE, EXEC, RESP; one operation is in flight at any time.
REQ-016 IDLE: req_ready is one-hot for the granted requester when any req_valid is set, else 0; req_ready is 0 in EXEC and RESP.
REQ-017 Arbitration: round-robin; when both request in IDLE, grant goes to the requester not served last; after reset, requester 0 wins the first tie.
REQ-018 The priority pointer updates only at the RESP handshake, not at grant.
REQ-019 On acceptance, a, b, code and grant index are registered and state moves IDLE->EXEC.
REQ-020 EXEC: result computed from the registered operands and registered into rsp_ans/rsp_err; state moves EXEC->RESP unconditionally.
REQ-021 Opcodes: 1 a+b; 2 a-b; 3 a<<b; 4 a>>b (logical); 5 logical AND (1 if both nonzero, else 0); 6 logical OR; 7 bitwise NOT a.
REQ-022 Arithmetic wraps modulo 2^WIDTH; no carry/borrow output; shift amounts >= WIDTH give 0.
REQ-023 Opcodes 0 and 8..15: rsp_ans = 0, rsp_err = 1; the block does not stall or print.
REQ-024 RESP: rsp_valid[grant] = 1, rsp_ans/rsp_err held stable until rsp_ready[grant] = 1; then RESP->IDLE.
REQ-025 rsp_ready on the non-granted bit is ignored.
REQ-026 Latency: acceptance in cycle N gives rsp_valid in cycle N+2; earliest next acceptance is the cycle after the response handshake.
REQ-027 Requests arriving while busy are not dropped; they wait for req_ready (requester holds valid and operands).

Reset
REQ-028 rst high at a clock edge forces state IDLE, priority pointer to requester 0, rsp_ans = 0, rsp_err = 0, from any state including mid-operation.
REQ-029 During and after reset: req_ready = 0 while rst is high, rsp_valid = 0, busy = 0; an in-flight operation is discarded with no response.

Structure
REQ-030 Shared package holds the opcode constants (OP_ADD = 1 ... OP_NOT = 7), the state encoding, and default WIDTH/CODE_W.
REQ-031 One sub-module, alu_core: purely combinational, (a, b, code) -> (ans, err) per REQ-021..023; the arbiter instantiates it once.

Verification
REQ-032 Single op: req0 a=3 b=5 code=1, rsp_ready=1 -> rsp_valid[0] two cycles after accept, rsp_ans=8, rsp_err=0.
REQ-033 Wrap/shift: a=2 b=5 code=2 -> ans=13; a=1 b=4 code=3 -> ans=0; a=9 b=0 code=7 -> ans=6.
REQ-034 Tie fairness: both valid continuously after reset -> grants 0,1,0,1; each rsp_valid only on its own bit.
REQ-035 Backpressure: rsp_ready low 5 cycles -> rsp_valid and rsp_ans stable, req_ready stays 0 throughout.
REQ-036 Invalid code: code=0 and code=12 -> rsp_ans=0, rsp_err=1, normal latency and handshake.
REQ-037 Reset in EXEC: rst for 1 cycle -> no rsp_valid, busy=0 next cycle, requester 0 wins next tie.
